hazard_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage 8-bit pipeline; consumer end of the ID/EX register interface.
- Compares source fields of the instruction in ID against the destination and control fields latched in ID/EX.
- Drives PC/IF_ID hold, bubble insertion into ID/EX (all control bits forced 0), and IF_ID/ID_EX flush on a taken branch from EX.
- Multi-cycle stalls and flushes are sequenced by an internal FSM with a down-counter.

---
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage 8-bit pipeline.
// It compares the source fields of the instruction in ID with the destination
// and control fields latched in ID/EX. From that it holds the PC and IF_ID,
// inserts bubbles into ID/EX, and squashes IF_ID/ID_EX after a taken branch.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   IF_ID_instruction[18:0] ID instruction: src1=[10:8], src2=[7:5], uses_src2=[18]
//   ID_EX_instruction[18:0] EX instruction: dest=[13:11]
//   ID_EX_reg_write         EX instruction writes the register file
//   ID_EX_reg_write_mux     2'b01 means a load (write-back from data memory)
//   ID_EX_write_c           EX instruction writes carry
//   alu_use_carry           ID instruction reads carry
//   branch_taken            EX resolved a taken branch
//   pc_write, IF_ID_write   advance enables (0 = hold)
//   ID_EX_bubble            ID_EX loads all-zero control
//   IF_ID_flush             IF_ID loads a NOP
//   busy                    sequencer is not idle
//   stall_count, flush_count  saturating statistics (only with HAZARD_STATS_EN)
//
// Optional feature macro: HAZARD_STATS_EN adds the two statistics counters.
// The outputs are combinational from the state and the current inputs. This
// lets the first stall or flush cycle take effect in the cycle it is detected.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] IF_ID_instruction,
    input  logic [18:0] ID_EX_instruction,
    input  logic        ID_EX_reg_write,
    input  logic [1:0]  ID_EX_reg_write_mux,
    input  logic        ID_EX_write_c,
    input  logic        alu_use_carry,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        ID_EX_bubble,
    output logic        IF_ID_flush,
    output logic        busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned STAT_W = 16;
    // The detect cycle in IDLE is the first stall/flush cycle.
    // The load values are the cycles still left after that one.
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           eff_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       dest;
    logic [2:0]       src1;
    logic [2:0]       src2;
    logic             uses_src2;
    logic             is_load;
    logic             load_hazard;
    logic             flag_hazard;
    logic             hazard;
    logic             unused_bits;

    assign dest      = ID_EX_instruction[13:11];
    assign src1      = IF_ID_instruction[10:8];
    assign src2      = IF_ID_instruction[7:5];
    assign uses_src2 = IF_ID_instruction[18];
    assign is_load   = (ID_EX_reg_write_mux == 2'b01);

    assign load_hazard = ID_EX_reg_write & is_load & (dest != 3'd0) &
                         ((dest == src1) | (uses_src2 & (dest == src2)));
    assign flag_hazard = ID_EX_write_c & alu_use_carry & is_load;
    assign hazard      = load_hazard | flag_hazard;

    // Instruction bits that the hazard compare does not look at.
    assign unused_bits = ^{IF_ID_instruction[17:11], IF_ID_instruction[4:0],
                           ID_EX_instruction[18:14], ID_EX_instruction[10:0]};

    // While reset is held, the outputs act as if the state were IDLE.
    assign eff_state = reset ? state : IDLE;

    // Output decode. A branch overrides everything, in any state.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        busy         = (eff_state != IDLE);
        if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else begin
            case (eff_state)
                IDLE: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end
                end
                STALL: begin
                    pc_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                end
                FLUSH: begin
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer. In STALL/FLUSH, cnt holds the cycles left including the current one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (branch_taken) begin
            state <= (FLUSH_LOAD == '0) ? IDLE : FLUSH;
            cnt   <= FLUSH_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        state <= (STALL_LOAD == '0) ? IDLE : STALL;
                        cnt   <= STALL_LOAD;
                    end
                end
                STALL, FLUSH: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic hazard_bubble;

    // A bubble without a flush can only come from a hazard stall.
    assign hazard_bubble = ID_EX_bubble & ~IF_ID_flush;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hazard_bubble && (stall_count != '1)) begin
                stall_count <= stall_count + STAT_W'(1);
            end
            if (IF_ID_flush && (flush_count != '1)) begin
                flush_count <= flush_count + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. It runs two instances side by side:
//   dut 0: LOAD_STALL=1, FLUSH_CYCLES=2 (defaults)
//   dut 1: LOAD_STALL=3, FLUSH_CYCLES=2
// The reference model tracks how many stall and flush cycles are still owed.
// It uses these counts per configuration and derives the expected outputs directly.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] if_id;
    logic [18:0] id_ex;
    logic        rw;
    logic [1:0]  mux;
    logic        wc;
    logic        auc;
    logic        bt;

    logic pw_a, iw_a, bb_a, fl_a, bz_a;
    logic pw_b, iw_b, bb_b, fl_b, bz_b;
`ifdef HAZARD_STATS_EN
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [15:0] obs_sc [2];
    logic [15:0] obs_fc [2];
`endif
    logic [4:0]  obs [2];

    int vectors     = 0;
    int miscompares = 0;

    // model state per configuration
    int         ls_p [2];
    int         fc_p [2];
    int         fl_m [2];
    int         sl_m [2];
    int         sc_m [2];
    int         fcn_m [2];
    int         fl_n [2];
    int         sl_n [2];
    int         sc_n [2];
    int         fcn_n [2];
    logic [4:0] exp_o [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1), .FLUSH_CYCLES(2)) u_a (
        .clk(clk), .reset(reset),
        .IF_ID_instruction(if_id), .ID_EX_instruction(id_ex),
        .ID_EX_reg_write(rw), .ID_EX_reg_write_mux(mux),
        .ID_EX_write_c(wc), .alu_use_carry(auc), .branch_taken(bt),
        .pc_write(pw_a), .IF_ID_write(iw_a), .ID_EX_bubble(bb_a),
        .IF_ID_flush(fl_a), .busy(bz_a)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc_a), .flush_count(fc_a)
`endif
    );

    hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2)) u_b (
        .clk(clk), .reset(reset),
        .IF_ID_instruction(if_id), .ID_EX_instruction(id_ex),
        .ID_EX_reg_write(rw), .ID_EX_reg_write_mux(mux),
        .ID_EX_write_c(wc), .alu_use_carry(auc), .branch_taken(bt),
        .pc_write(pw_b), .IF_ID_write(iw_b), .ID_EX_bubble(bb_b),
        .IF_ID_flush(fl_b), .busy(bz_b)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc_b), .flush_count(fc_b)
`endif
    );

    always_comb begin
        obs[0] = {pw_a, iw_a, bb_a, fl_a, bz_a};
        obs[1] = {pw_b, iw_b, bb_b, fl_b, bz_b};
`ifdef HAZARD_STATS_EN
        obs_sc[0] = sc_a;
        obs_sc[1] = sc_b;
        obs_fc[0] = fc_a;
        obs_fc[1] = fc_b;
`endif
    end

    // Expected {pc_write, IF_ID_write, bubble, flush, busy} for the applied inputs.
    task automatic model_eval();
        logic [2:0] dest, s1, s2;
        logic       hz;
        dest = id_ex[13:11];
        s1   = if_id[10:8];
        s2   = if_id[7:5];
        hz   = (rw && mux == 2'b01 && dest != 3'd0 &&
                (dest == s1 || (if_id[18] && dest == s2))) ||
               (wc && auc && mux == 2'b01);
        for (int k = 0; k < 2; k++) begin
            logic pw, iw, bb, fo, bz, hzb;
            pw = 1'b1; iw = 1'b1; bb = 1'b0; fo = 1'b0; bz = 1'b0; hzb = 1'b0;
            fl_n[k]  = fl_m[k];
            sl_n[k]  = sl_m[k];
            sc_n[k]  = sc_m[k];
            fcn_n[k] = fcn_m[k];
            if (!reset) begin
                if (bt) begin fo = 1'b1; bb = 1'b1; end
                else if (hz) begin pw = 1'b0; iw = 1'b0; bb = 1'b1; end
                fl_n[k] = 0; sl_n[k] = 0; sc_n[k] = 0; fcn_n[k] = 0;
            end else begin
                bz = (fl_m[k] > 0) || (sl_m[k] > 0);
                if (bt) begin
                    fo = 1'b1; bb = 1'b1;
                    fl_n[k] = fc_p[k] - 1;
                    sl_n[k] = 0;
                end else if (fl_m[k] > 0) begin
                    fo = 1'b1; bb = 1'b1;
                    fl_n[k] = fl_m[k] - 1;
                end else if (sl_m[k] > 0) begin
                    pw = 1'b0; iw = 1'b0; bb = 1'b1; hzb = 1'b1;
                    sl_n[k] = sl_m[k] - 1;
                end else if (hz) begin
                    pw = 1'b0; iw = 1'b0; bb = 1'b1; hzb = 1'b1;
                    sl_n[k] = ls_p[k] - 1;
                end
                if (hzb && sc_m[k] < 65535) sc_n[k] = sc_m[k] + 1;
                if (fo && fcn_m[k] < 65535) fcn_n[k] = fcn_m[k] + 1;
            end
            exp_o[k] = {pw, iw, bb, fo, bz};
        end
    endtask

    task automatic set_in(input logic r, input logic [18:0] ifd, input logic [18:0] ide,
                          input logic rwi, input logic [1:0] mi, input logic wci,
                          input logic auci, input logic bti);
        reset = r; if_id = ifd; id_ex = ide; rw = rwi; mux = mi;
        wc = wci; auc = auci; bt = bti;
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            fl_m[k]  = fl_n[k];
            sl_m[k]  = sl_n[k];
            sc_m[k]  = sc_n[k];
            fcn_m[k] = fcn_n[k];
        end
        @(negedge clk);
    endtask

    task automatic idle_in(input logic r);
        set_in(r, 19'd0, 19'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        idle_in(1'b0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_o[k]) begin
                $display("FAIL reset_init dut%0d got %b exp %b", k, obs[k], exp_o[k]);
                miscompares++;
            end
        end
        tick();
        idle_in(1'b0);
        tick();
        // enter FLUSH, then hold reset low for two cycles
        set_in(1'b1, 19'd0, 19'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            idle_in(c == 2);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_o[k]) begin
                    $display("FAIL reset_flush c%0d dut%0d got %b exp %b", c, k, obs[k], exp_o[k]);
                    miscompares++;
                end
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)
                set_in(1'b1, 19'(3 << 8), 19'(3 << 11), 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            else
                set_in(1'b1, 19'(3 << 8), 19'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_o[k]) begin
                    $display("FAIL load_use c%0d dut%0d got %b exp %b", c, k, obs[k], exp_o[k]);
                    miscompares++;
                end
            end
            tick();
        end
    endtask

    task automatic test_no_false_hazard();
        logic [18:0] ifs [4];
        logic [18:0] ids [4];
        logic [1:0]  ms  [4];
        ifs[0] = 19'd0;                      ids[0] = 19'd0;        ms[0] = 2'b01; // dest 0
        ifs[1] = 19'((5 << 8) | (2 << 5));   ids[1] = 19'(2 << 11); ms[1] = 2'b01; // src2 unused
        ifs[2] = 19'(4 << 8);                ids[2] = 19'(4 << 11); ms[2] = 2'b00; // not a load
        ifs[3] = 19'(4 << 8);                ids[3] = 19'(4 << 11); ms[3] = 2'b10;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, ifs[c], ids[c], 1'b1, ms[c], 1'b0, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_o[k] || obs[k][4] !== 1'b1) begin
                    $display("FAIL no_false_hazard c%0d dut%0d got %b exp %b", c, k, obs[k], exp_o[k]);
                    miscompares++;
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 19'd0, 19'd0, 1'b0, 2'b00, 1'b0, 1'b0, c == 0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_o[k]) begin
                    $display("FAIL branch c%0d dut%0d got %b exp %b", c, k, obs[k], exp_o[k]);
                    miscompares++;
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_in_stall();
        for (int c = 0; c < 6; c++) begin
            if (c == 0)
                set_in(1'b1, 19'(6 << 8), 19'(6 << 11), 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            else
                set_in(1'b1, 19'd0, 19'd0, 1'b0, 2'b00, 1'b0, 1'b0, c == 1);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_o[k]) begin
                    $display("FAIL branch_in_stall c%0d dut%0d got %b exp %b", c, k, obs[k], exp_o[k]);
                    miscompares++;
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [18:0] ifd, ide;
            ifd = 19'($urandom);
            ide = 19'($urandom);
            ifd[10:8] = 3'($urandom_range(0, 3));
            ifd[7:5]  = 3'($urandom_range(0, 3));
            ide[13:11] = 3'($urandom_range(0, 3));
            set_in($urandom_range(0, 49) != 0, ifd, ide, 1'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_o[k]) begin
                    $display("FAIL random c%0d dut%0d got %b exp %b", c, k, obs[k], exp_o[k]);
                    miscompares++;
                end
`ifdef HAZARD_STATS_EN
                vectors++;
                if (obs_sc[k] !== 16'(sc_m[k]) || obs_fc[k] !== 16'(fcn_m[k])) begin
                    $display("FAIL random_stats c%0d dut%0d got %0d/%0d exp %0d/%0d",
                             c, k, obs_sc[k], obs_fc[k], sc_m[k], fcn_m[k]);
                    miscompares++;
                end
`endif
            end
            tick();
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        idle_in(1'b0);
        tick();
        for (int h = 0; h < 3; h++) begin
            set_in(1'b1, 19'(2 << 8), 19'(2 << 11), 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            tick();
            for (int c = 0; c < 3; c++) begin idle_in(1'b1); tick(); end
        end
        set_in(1'b1, 19'd0, 19'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin idle_in(1'b1); tick(); end
        vectors++;
        if (sc_a !== 16'd3 || fc_a !== 16'd2) begin
            $display("FAIL stats_counts got %0d/%0d exp 3/2", sc_a, fc_a);
            miscompares++;
        end
        vectors++;
        if (sc_b !== 16'(sc_m[1]) || fc_b !== 16'(fcn_m[1])) begin
            $display("FAIL stats_counts_b got %0d/%0d exp %0d/%0d", sc_b, fc_b, sc_m[1], fcn_m[1]);
            miscompares++;
        end
        // continuous hazard drives the stall counter into saturation
        for (int c = 0; c < 65540; c++) begin
            set_in(1'b1, 19'(2 << 8), 19'(2 << 11), 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_sc[k] !== 16'hFFFF || obs_sc[k] !== 16'(sc_m[k])) begin
                $display("FAIL stats_saturate dut%0d got %h exp ffff", k, obs_sc[k]);
                miscompares++;
            end
        end
        idle_in(1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_sc[k] !== 16'd0 || obs_fc[k] !== 16'd0) begin
                $display("FAIL stats_clear dut%0d got %0d/%0d exp 0/0", k, obs_sc[k], obs_fc[k]);
                miscompares++;
            end
        end
    endtask
`endif

    initial begin
        ls_p[0] = 1; fc_p[0] = 2;
        ls_p[1] = 3; fc_p[1] = 2;
        for (int k = 0; k < 2; k++) begin
            fl_m[k] = 0; sl_m[k] = 0; sc_m[k] = 0; fcn_m[k] = 0;
        end
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch();
        test_branch_in_stall();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
